// File: rtl/mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared types and defaults for the two-master memory/IO bus arbiter.
//   owner_e   : bus owner / pending-read encoding (NONE, M0, M1)
//   owner_of  : maps a "master 1 granted" flag onto the owner encoding
// ---------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    function automatic owner_e owner_of(input logic is_m1);
        return is_m1 ? OWN_M1 : OWN_M0;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
// One requester port of the arbiter.
//   master modport : the requesting agent (CPU or DMA/video fetch)
//   slave modport  : the arbiter side
//   req/addr/wdata/we/lock : request, held stable until ack is seen high
//   ack                    : access issued on this clock edge
//   rdata/rvalid           : read return, one cycle after the acked read
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              lock;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (output req, addr, wdata, we, lock,
                    input  ack, rdata, rvalid);

    modport slave  (input  req, addr, wdata, we, lock,
                    output ack, rdata, rvalid);
endinterface

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin picker.
//   req0, req1 : requests
//   last       : 1 = master 1 was granted most recently, 0 = master 0
//   gnt0, gnt1 : one-hot (or zero) grant; a tie goes to the master that
//                was not granted last
// ---------------------------------------------------------------------------
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt0,
    output logic gnt1
);
    assign gnt0 = req0 & (~req1 |  last);
    assign gnt1 = req1 & (~req0 | ~last);
endmodule

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Shares a single-ported synchronous memory/IO bus between master 0 (CPU)
// and master 1 (DMA/video fetch). One access per cycle, round-robin on
// contention, optional locked bursts of up to MAX_BURST accesses.
//   clk, rst         : clock, asynchronous active-high reset
//   m0, m1           : requester ports (slave modport)
//   bus_addr         : address to memory/IO
//   bus_data_in      : write data to memory/IO
//   bus_data_out     : read data from memory/IO, valid the cycle after addr
//   bus_write_enable : write strobe to memory/IO
// ---------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.slave  m0,
    mem_bus_arbiter_if.slave  m1,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data_in,
    input  logic [DATA_W-1:0] bus_data_out,
    output logic              bus_write_enable
);

    localparam int              CNT_W    = $clog2(MAX_BURST + 1);
    // Count value at which the next owner access is the last of the burst.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    owner_e           owner_q, owner_d;
    owner_e           rd_pend_q, rd_pend_d;
    logic             last_q, last_d;       // 1 = master 1 was granted last
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic pick0, pick1;
    logic gnt0, gnt1, gnt_any, gnt_lock, gnt_we;
    logic owner_hold;

    rr_pick2 u_pick (
        .req0 (m0.req),
        .req1 (m1.req),
        .last (last_q),
        .gnt0 (pick0),
        .gnt1 (pick1)
    );

    // Grant selection. A burst owner that keeps requesting is served
    // exclusively; an owner that drops req releases the bus in the same
    // cycle and the picker decides as if nobody owned it.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        owner_hold = (owner_q == OWN_M0 && m0.req) || (owner_q == OWN_M1 && m1.req);
        if (!rst) begin
            if (owner_hold) begin
                gnt0 = (owner_q == OWN_M0);
                gnt1 = (owner_q == OWN_M1);
            end else begin
                gnt0 = pick0;
                gnt1 = pick1;
            end
        end
    end

    always_comb begin
        owner_d     = owner_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        rd_pend_d   = OWN_NONE;
        gnt_any     = gnt0 | gnt1;
        gnt_lock    = gnt1 ? m1.lock : m0.lock;
        gnt_we      = gnt1 ? m1.we   : m0.we;

        if (gnt_any) begin
            last_d = gnt1;
            if (!gnt_we) begin
                rd_pend_d = owner_of(gnt1);
            end
        end

        if (owner_hold) begin
            if (!gnt_lock || burst_cnt_q == LAST_CNT) begin
                owner_d     = OWN_NONE;
                burst_cnt_d = '0;
            end else begin
                burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
        end else if (gnt_any && gnt_lock) begin
            owner_d     = owner_of(gnt1);
            burst_cnt_d = CNT_W'(1);
        end else begin
            owner_d     = OWN_NONE;
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= OWN_NONE;
            last_q      <= 1'b1;        // master 0 wins the first tie
            burst_cnt_q <= '0;
            rd_pend_q   <= OWN_NONE;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop, independent of order.
            owner_q     <= owner_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    // Bus mux: master 0 drives the idle bus; the write strobe is the only
    // bus signal that must be quiet without a grant.
    assign m0.ack           = gnt0;
    assign m1.ack           = gnt1;
    assign bus_addr         = gnt1 ? m1.addr  : m0.addr;
    assign bus_data_in      = gnt1 ? m1.wdata : m0.wdata;
    assign bus_write_enable = gnt_any & gnt_we;

    // Read return: the bus already delays data by one cycle, so only the
    // valid strobe needs steering.
    assign m0.rvalid = (rd_pend_q == OWN_M0);
    assign m1.rvalid = (rd_pend_q == OWN_M1);
    assign m0.rdata  = bus_data_out;
    assign m1.rdata  = bus_data_out;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter with a registered-read memory model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic        bus_write_enable;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter_if #(.ADDR_W(16), .DATA_W(8)) m0_if ();
    mem_bus_arbiter_if #(.ADDR_W(16), .DATA_W(8)) m1_if ();

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_BURST(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .m0               (m0_if),
        .m1               (m1_if),
        .bus_addr         (bus_addr),
        .bus_data_in      (bus_data_in),
        .bus_data_out     (bus_data_out),
        .bus_write_enable (bus_write_enable)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data is valid the cycle after the address.
    logic [7:0] mem [0:65535];
    logic [7:0] rd_q;
    always @(posedge clk) begin
        if (rst) begin
            mem[16'h0010] <= 8'hA5;
            mem[16'h0011] <= 8'h5A;
            mem[16'h0020] <= 8'hC3;
        end else if (bus_write_enable) begin
            mem[bus_addr] <= bus_data_in;
        end
        rd_q <= mem[bus_addr];
    end
    assign bus_data_out = rd_q;

    task automatic set_m0(input logic req, input logic [15:0] addr, input logic we,
                          input logic [7:0] wdata, input logic lock);
        m0_if.req = req; m0_if.addr = addr; m0_if.we = we; m0_if.wdata = wdata; m0_if.lock = lock;
    endtask

    task automatic set_m1(input logic req, input logic [15:0] addr, input logic we,
                          input logic [7:0] wdata, input logic lock);
        m1_if.req = req; m1_if.addr = addr; m1_if.we = we; m1_if.wdata = wdata; m1_if.lock = lock;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_m0(1'b1, 16'h0010, 1'b0, 8'h00, 1'b0);
        set_m1(1'b1, 16'h0011, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        checks += 5;
        if (m0_if.ack !== 1'b0)    begin errors++; $display("FAIL reset_m0_ack got %b exp 0", m0_if.ack); end
        if (m1_if.ack !== 1'b0)    begin errors++; $display("FAIL reset_m1_ack got %b exp 0", m1_if.ack); end
        if (m0_if.rvalid !== 1'b0) begin errors++; $display("FAIL reset_m0_rvalid got %b exp 0", m0_if.rvalid); end
        if (m1_if.rvalid !== 1'b0) begin errors++; $display("FAIL reset_m1_rvalid got %b exp 0", m1_if.rvalid); end
        if (bus_write_enable !== 1'b0) begin errors++; $display("FAIL reset_bus_we got %b exp 0", bus_write_enable); end
        set_m0(1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
        set_m1(1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        next_cycle();
    endtask

    // Both masters read continuously: M0, M1, M0, ... each with its own rvalid.
    task automatic test_round_robin();
        logic exp0;
        set_m0(1'b1, 16'h0010, 1'b0, 8'h00, 1'b0);
        set_m1(1'b1, 16'h0011, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp0 = (c % 2 == 0);
            checks += 2;
            if (m0_if.ack !== exp0)  begin errors++; $display("FAIL rr_m0_ack c=%0d got %b exp %b", c, m0_if.ack, exp0); end
            if (m1_if.ack !== !exp0) begin errors++; $display("FAIL rr_m1_ack c=%0d got %b exp %b", c, m1_if.ack, !exp0); end
            if (c > 0) begin
                checks += 3;
                if (m0_if.rvalid !== !exp0) begin errors++; $display("FAIL rr_m0_rvalid c=%0d got %b exp %b", c, m0_if.rvalid, !exp0); end
                if (m1_if.rvalid !== exp0)  begin errors++; $display("FAIL rr_m1_rvalid c=%0d got %b exp %b", c, m1_if.rvalid, exp0); end
                if (bus_data_out !== (exp0 ? 8'h5A : 8'hA5)) begin
                    errors++; $display("FAIL rr_rdata c=%0d got %h exp %h", c, bus_data_out, exp0 ? 8'h5A : 8'hA5);
                end
            end
            next_cycle();
        end
        set_m0(1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
        set_m1(1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checks += 2;
        if (m1_if.rvalid !== 1'b1) begin errors++; $display("FAIL rr_last_m1_rvalid got %b exp 1", m1_if.rvalid); end
        if (m1_if.rdata !== 8'h5A) begin errors++; $display("FAIL rr_last_m1_rdata got %h exp 5a", m1_if.rdata); end
        next_cycle();
    endtask

    task automatic test_single_read();
        set_m0(1'b1, 16'h0010, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checks += 4;
        if (m0_if.ack !== 1'b1)     begin errors++; $display("FAIL rd_m0_ack got %b exp 1", m0_if.ack); end
        if (m1_if.ack !== 1'b0)     begin errors++; $display("FAIL rd_m1_ack got %b exp 0", m1_if.ack); end
        if (bus_addr !== 16'h0010)  begin errors++; $display("FAIL rd_bus_addr got %h exp 0010", bus_addr); end
        if (bus_write_enable !== 1'b0) begin errors++; $display("FAIL rd_bus_we got %b exp 0", bus_write_enable); end
        next_cycle();
        set_m0(1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checks += 4;
        if (m0_if.rvalid !== 1'b1) begin errors++; $display("FAIL rd_m0_rvalid got %b exp 1", m0_if.rvalid); end
        if (m0_if.rdata !== 8'hA5) begin errors++; $display("FAIL rd_m0_rdata got %h exp a5", m0_if.rdata); end
        if (m1_if.rvalid !== 1'b0) begin errors++; $display("FAIL rd_m1_rvalid got %b exp 0", m1_if.rvalid); end
        if (m0_if.ack !== 1'b0)    begin errors++; $display("FAIL rd_m0_ack_after got %b exp 0", m0_if.ack); end
        next_cycle();
        @(negedge clk);
        checks += 1;
        if (m0_if.rvalid !== 1'b0) begin errors++; $display("FAIL rd_m0_rvalid_pulse got %b exp 0", m0_if.rvalid); end
        next_cycle();
    endtask

    // m1 locked burst of 20 writes against a competing m0 read (last grant = M0).
    task automatic test_burst();
        logic exp0, exp1;
        int   i;
        i = 0;
        set_m1(1'b1, 16'h8000, 1'b1, 8'h00, 1'b1);
        set_m0(1'b1, 16'h0020, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            exp1 = (c < 16) || (c >= 17);
            exp0 = (c == 16);
            checks += 2;
            if (m0_if.ack !== exp0) begin errors++; $display("FAIL burst_m0_ack c=%0d got %b exp %b", c, m0_if.ack, exp0); end
            if (m1_if.ack !== exp1) begin errors++; $display("FAIL burst_m1_ack c=%0d got %b exp %b", c, m1_if.ack, exp1); end
            if (exp1) begin
                checks += 2;
                if (bus_write_enable !== 1'b1) begin errors++; $display("FAIL burst_we c=%0d got %b exp 1", c, bus_write_enable); end
                if (bus_addr !== 16'(16'h8000 + i)) begin
                    errors++; $display("FAIL burst_addr c=%0d got %h exp %h", c, bus_addr, 16'(16'h8000 + i));
                end
            end
            if (c == 17) begin
                checks += 2;
                if (m0_if.rvalid !== 1'b1) begin errors++; $display("FAIL burst_m0_rvalid got %b exp 1", m0_if.rvalid); end
                if (m0_if.rdata !== 8'hC3) begin errors++; $display("FAIL burst_m0_rdata got %h exp c3", m0_if.rdata); end
            end
            next_cycle();
            if (exp0) m0_if.req = 1'b0;
            if (exp1) begin
                i++;
                if (i == 20) m1_if.req = 1'b0;
                else begin
                    m1_if.addr  = 16'(16'h8000 + i);
                    m1_if.wdata = 8'(i);
                end
            end
        end
        checks += 3;
        if (mem[16'h8000] !== 8'd0)  begin errors++; $display("FAIL burst_mem0 got %h exp 00", mem[16'h8000]); end
        if (mem[16'h800F] !== 8'd15) begin errors++; $display("FAIL burst_mem15 got %h exp 0f", mem[16'h800F]); end
        if (mem[16'h8013] !== 8'd19) begin errors++; $display("FAIL burst_mem19 got %h exp 13", mem[16'h8013]); end
        set_m1(1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_io_write();
        set_m1(1'b1, 16'h8400, 1'b1, 8'h3C, 1'b0);
        @(negedge clk);
        checks += 4;
        if (m1_if.ack !== 1'b1)        begin errors++; $display("FAIL io_m1_ack got %b exp 1", m1_if.ack); end
        if (bus_write_enable !== 1'b1) begin errors++; $display("FAIL io_we got %b exp 1", bus_write_enable); end
        if (bus_addr !== 16'h8400)     begin errors++; $display("FAIL io_addr got %h exp 8400", bus_addr); end
        if (bus_data_in !== 8'h3C)     begin errors++; $display("FAIL io_data got %h exp 3c", bus_data_in); end
        next_cycle();
        set_m1(1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checks += 3;
        if (bus_write_enable !== 1'b0) begin errors++; $display("FAIL io_we_after got %b exp 0", bus_write_enable); end
        if (m1_if.rvalid !== 1'b0)     begin errors++; $display("FAIL io_m1_rvalid got %b exp 0", m1_if.rvalid); end
        if (mem[16'h8400] !== 8'h3C)   begin errors++; $display("FAIL io_mem got %h exp 3c", mem[16'h8400]); end
        next_cycle();
    endtask

    // m0 locks, then drops req on its third cycle; m1 must win that cycle.
    task automatic test_lock_drop();
        set_m0(1'b1, 16'h0010, 1'b0, 8'h00, 1'b1);
        set_m1(1'b1, 16'h0011, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks += 2;
            if (m0_if.ack !== 1'b1) begin errors++; $display("FAIL lock_m0_ack c=%0d got %b exp 1", c, m0_if.ack); end
            if (m1_if.ack !== 1'b0) begin errors++; $display("FAIL lock_m1_ack c=%0d got %b exp 0", c, m1_if.ack); end
            next_cycle();
        end
        m0_if.req = 1'b0;
        @(negedge clk);
        checks += 3;
        if (m1_if.ack !== 1'b1)    begin errors++; $display("FAIL drop_m1_ack got %b exp 1", m1_if.ack); end
        if (m0_if.ack !== 1'b0)    begin errors++; $display("FAIL drop_m0_ack got %b exp 0", m0_if.ack); end
        if (m0_if.rvalid !== 1'b1) begin errors++; $display("FAIL drop_m0_rvalid got %b exp 1", m0_if.rvalid); end
        next_cycle();
        set_m0(1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
        set_m1(1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checks += 2;
        if (m1_if.rvalid !== 1'b1) begin errors++; $display("FAIL drop_m1_rvalid got %b exp 1", m1_if.rvalid); end
        if (m1_if.rdata !== 8'h5A) begin errors++; $display("FAIL drop_m1_rdata got %h exp 5a", m1_if.rdata); end
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        set_m0(1'b1, 16'h0010, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        checks += 1;
        if (m0_if.ack !== 1'b1) begin errors++; $display("FAIL rmb_m0_ack got %b exp 1", m0_if.ack); end
        next_cycle();
        set_m1(1'b1, 16'h0011, 1'b0, 8'h00, 1'b0);
        #1;
        checks += 2;
        if (m0_if.rvalid !== 1'b1) begin errors++; $display("FAIL rmb_pre_rvalid got %b exp 1", m0_if.rvalid); end
        if (m1_if.ack !== 1'b0)    begin errors++; $display("FAIL rmb_pre_m1_ack got %b exp 0", m1_if.ack); end
        rst = 1'b1;
        #1;
        checks += 4;
        if (m0_if.ack !== 1'b0)    begin errors++; $display("FAIL rmb_m0_ack got %b exp 0", m0_if.ack); end
        if (m1_if.ack !== 1'b0)    begin errors++; $display("FAIL rmb_m1_ack got %b exp 0", m1_if.ack); end
        if (m0_if.rvalid !== 1'b0) begin errors++; $display("FAIL rmb_m0_rvalid got %b exp 0", m0_if.rvalid); end
        if (bus_write_enable !== 1'b0) begin errors++; $display("FAIL rmb_we got %b exp 0", bus_write_enable); end
        @(negedge clk);
        rst = 1'b0;
        m0_if.lock = 1'b0;
        #1;
        checks += 3;
        if (m0_if.rvalid !== 1'b0) begin errors++; $display("FAIL rmb_post_rvalid got %b exp 0", m0_if.rvalid); end
        if (m0_if.ack !== 1'b1)    begin errors++; $display("FAIL rmb_tie_m0_ack got %b exp 1", m0_if.ack); end
        if (m1_if.ack !== 1'b0)    begin errors++; $display("FAIL rmb_tie_m1_ack got %b exp 0", m1_if.ack); end
        next_cycle();
        set_m0(1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
        set_m1(1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_read();
        test_burst();
        test_io_write();
        test_lock_drop();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter in front of the synchronous memory/IO bus (RAM banks, boot ROM, IO port at 16'h8400), whose read data is valid the clock tick after the address. Shares that single-ported bus between master 0 (CPU) and master 1 (DMA/video fetch), issuing at most one access per cycle. Round-robin on contention, with optional locked bursts. Returns each read with a one-cycle-delayed valid strobe.

## Interface
- ADDR_W, 16, bus address width
- DATA_W, 8, bus data width
- MAX_BURST, 16, maximum accesses per locked burst (≥2)

- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mN_req  in  1  master N (N=0,1) requests an access this cycle
- mN_addr  in  ADDR_W  access address
- mN_wdata  in  DATA_W  write data
- mN_we  in  1  1 = write, 0 = read
- mN_lock  in  1  keep bus ownership after this access
- mN_ack  out  1  access accepted; issued on this clock edge
- mN_rdata  out  DATA_W  read data; valid when mN_rvalid
- mN_rvalid  out  1  one-cycle pulse, cycle after an acked read
- bus_addr  out  ADDR_W  to memory/IO address
- bus_data_in  out  DATA_W  to memory/IO write data
- bus_data_out  in  DATA_W  from memory/IO read data (registered-address timing)
- bus_write_enable  out  1  to memory/IO write strobe

## Operation
- State: owner ∈ {NONE, M0, M1}; last_grant ∈ {M0, M1}; burst_cnt (clog2(MAX_BURST+1) bits); rd_pend ∈ {none, M0, M1}.
- owner = NONE:
  - Exactly one req → grant it.
  - Both req → grant the master ≠ last_grant.
  - Granted master: ack=1; last_grant <= it.
  - If its lock=1 → owner <= it, burst_cnt <= 1.
- owner = M0/M1:
  - Only the owner may be acked; the other master's ack=0.
  - Owner req=1: ack. If lock=0 or burst_cnt+1 == MAX_BURST, this is the final access; owner <= NONE next cycle. Otherwise burst_cnt++.
  - Owner req=0: ownership drops combinationally this cycle; arbitrate as for owner=NONE in the same cycle; owner <= NONE.
- Bus mux: bus_addr, bus_data_in and bus_write_enable (= ack & we) come from the granted master.
  - With no grant: bus_addr/bus_data_in = m0 values, bus_write_enable = 0.
- Read return: an acked read sets rd_pend <= granted master; writes and idle cycles clear it.
  - mN_rvalid = (rd_pend == N).
  - mN_rdata = bus_data_out, combinational passthrough for both masters.
- Acked writes produce no rvalid.

## Timing
- Grant latency 0: ack is combinational from req/lock/state in the same cycle; the access is committed at that rising edge.
- Read latency 1: rvalid/rdata appear in the cycle after the ack edge.
- Throughput: one access per cycle. Back-to-back reads from alternating masters each get their own rvalid.
- Masters must hold req/addr/we/wdata/lock stable until ack is sampled high.
- Contention: a non-locking master never waits more than 1 cycle behind the other non-locked master. Worst case behind a burst is MAX_BURST cycles.
- Reset values, asserted asynchronously:
  - owner=NONE, last_grant=M1 (M0 wins the first tie), burst_cnt=0, rd_pend=none.
  - mN_ack=0, mN_rvalid=0, bus_write_enable=0.
- Reset mid-burst aborts ownership. An rvalid pending from the access before reset is dropped.
- Simultaneous final burst access and other master's req: the other master wins the next tie (last_grant = burst owner).

## Structure
- Package mem_bus_arbiter_pkg: owner encoding OWN_NONE=2'd0, OWN_M0=2'd1, OWN_M1=2'd2; shared ADDR_W/DATA_W defaults.
- Sub-module rr_pick2: combinational two-way round-robin picker. Inputs req0, req1, last; outputs gnt0, gnt1. Instantiated once.
- Top holds owner/burst/rd_pend registers, the bus mux and the rvalid steering.

## Test plan
- Reset, then m0 read 16'h0010 (RAM preloaded 8'hA5) → m0_ack same cycle; next cycle m0_rvalid=1, m0_rdata=8'hA5; m1 signals silent.
- Both masters request continuously, no lock → acks alternate M0, M1, M0, …; M0 first after reset.
- m1 lock=1 for 20 writes to 16'h8000+i while m0 requests, MAX_BURST=16 → m1 acked 16 consecutive cycles; then m0 acked; then m1 resumes.
- m1 write 8'h3C to 16'h8400 → bus_write_enable=1 for exactly one cycle with bus_addr=16'h8400; no m1_rvalid.
- m0 locked burst; m0 drops req on cycle 3 while m1 requests → m1 acked that same cycle.
- Assert rst mid-burst with a read pending → all acks/rvalids 0 immediately. After release, tie goes to M0.
